// File: rtl/conv_result_writeback_pkg.sv
// Shared widths, defaults and FSM state encoding for the convolution result writeback block.
package conv_result_writeback_pkg;

    localparam int CRW_RESULT_SIZE = 32;
    localparam int CRW_DATA_WIDTH  = 8;
    localparam int CRW_ADDR_SIZE   = 16;
    localparam int CRW_FIFO_DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } crw_state_e;

endpackage

// File: rtl/conv_result_writeback_if.sv
// Result RAM write port (upstream) plus output RAM valid/ready write channel.
interface conv_result_writeback_if
    import conv_result_writeback_pkg::*;
#(
    parameter int RESULT_SIZE = CRW_RESULT_SIZE,
    parameter int DATA_WIDTH  = CRW_DATA_WIDTH,
    parameter int ADDR_SIZE   = CRW_ADDR_SIZE
);

    logic                   in_ena;
    logic                   in_wea;
    logic [ADDR_SIZE-1:0]   in_addr;
    logic [RESULT_SIZE-1:0] in_data;
    logic                   in_w_done;

    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_SIZE-1:0]   out_addr;
    logic [DATA_WIDTH-1:0]  out_data;

    modport master (
        output in_ena, in_wea, in_addr, in_data, in_w_done, out_ready,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  in_ena, in_wea, in_addr, in_data, in_w_done, out_ready,
        output out_valid, out_addr, out_data
    );

endinterface

// File: rtl/conv_result_writeback_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    // Head is forced to zero when empty so stale storage never shows on the outputs.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/conv_result_writeback.sv
// Requantises GEMM results (round, shift, ReLU, saturate) and queues them for the output RAM.
//
// state | meaning
// IDLE  | waiting for start; inputs ignored
// RUN   | accepting result writes until in_w_done
// DRAIN | no new writes; flushing pipeline and FIFO
// DONE  | one-cycle done pulse, count check result visible
module conv_result_writeback
    import conv_result_writeback_pkg::*;
#(
    parameter int RESULT_SIZE = CRW_RESULT_SIZE,
    parameter int DATA_WIDTH  = CRW_DATA_WIDTH,
    parameter int ADDR_SIZE   = CRW_ADDR_SIZE,
    parameter int FIFO_DEPTH  = CRW_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu_en,
    input  logic [ADDR_SIZE-1:0]  cfg_expected,
    conv_result_writeback_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  count_err,
    output logic [ADDR_SIZE-1:0]  wr_count
);

    // One guard bit so the rounding add cannot wrap.
    localparam int RW = RESULT_SIZE + 1;
    localparam int FW = ADDR_SIZE + DATA_WIDTH;
    localparam logic signed [RW-1:0] SAT_MAX = RW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (DATA_WIDTH - 1)));

    crw_state_e              state_q, state_d;
    logic                    s1_vld_q;
    logic [ADDR_SIZE-1:0]    s1_addr_q;
    logic signed [RW-1:0]    s1_data_q;
    logic                    s2_vld_q;
    logic [ADDR_SIZE-1:0]    s2_addr_q;
    logic [DATA_WIDTH-1:0]   s2_data_q;
    logic [ADDR_SIZE-1:0]    wr_count_q;
    logic                    overflow_q;
    logic                    count_err_q;

    logic                    accept;
    logic                    clear;
    logic                    pop;
    logic                    push_drop;
    logic                    fifo_rst;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [FW-1:0]           fifo_dout;
    logic signed [RW-1:0]    in_ext;
    logic signed [RW-1:0]    rnd_ofs;
    logic signed [RW-1:0]    r1_d;
    logic signed [RW-1:0]    r_relu;
    logic [DATA_WIDTH-1:0]   sat_d;

    assign accept    = (state_q == ST_RUN) && bus.in_ena && bus.in_wea;
    assign clear     = (state_q == ST_IDLE) && start;
    assign pop       = bus.out_valid && bus.out_ready;
    assign push_drop = s2_vld_q && fifo_full && !pop;
    assign fifo_rst  = rst || clear;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (bus.in_w_done) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_vld_q && !s2_vld_q && fifo_empty) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
    end

    // Stage 1 arithmetic: round-half-up then arithmetic shift.
    always_comb begin
        in_ext  = {bus.in_data[RESULT_SIZE-1], bus.in_data};
        rnd_ofs = (cfg_shift != 5'd0) ? (RW'(1) << (cfg_shift - 5'd1)) : '0;
        r1_d    = (in_ext + rnd_ofs) >>> cfg_shift;
    end

    // Stage 2 arithmetic: optional ReLU, then clamp to the output word range.
    always_comb begin
        r_relu = s1_data_q;
        if (cfg_relu_en && s1_data_q[RW-1]) begin
            r_relu = '0;
        end
        if (r_relu > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_WIDTH-1:0];
        end else if (r_relu < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_d = r_relu[DATA_WIDTH-1:0];
        end
    end

    // Pipeline registers, write counter and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_addr_q   <= '0;
            s2_data_q   <= '0;
            wr_count_q  <= '0;
            overflow_q  <= 1'b0;
            count_err_q <= 1'b0;
        end else begin
            s1_vld_q  <= accept;
            s1_addr_q <= bus.in_addr;
            s1_data_q <= r1_d;
            s2_vld_q  <= s1_vld_q;
            s2_addr_q <= s1_addr_q;
            s2_data_q <= sat_d;
            if (clear) begin
                wr_count_q  <= '0;
                overflow_q  <= 1'b0;
                count_err_q <= 1'b0;
            end else begin
                if (accept && (wr_count_q != '1)) begin
                    wr_count_q <= wr_count_q + ADDR_SIZE'(1);
                end
                if (push_drop) begin
                    overflow_q <= 1'b1;
                end
                // Judged on entry to DONE so the flag is already valid alongside done.
                if ((state_q == ST_DRAIN) && (state_d == ST_DONE) && (wr_count_q != cfg_expected)) begin
                    count_err_q <= 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (fifo_rst),
        .push_i  (s2_vld_q),
        .data_i  ({s2_addr_q, s2_data_q}),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.out_valid = !fifo_empty;
    assign {bus.out_addr, bus.out_data} = fifo_dout;
    assign overflow  = overflow_q;
    assign count_err = count_err_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_conv_result_writeback.sv
// Randomised and directed bench for conv_result_writeback against a queue-based reference model.
module tb_conv_result_writeback;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_shift;
    logic        cfg_relu_en;
    logic [15:0] cfg_expected;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        count_err;
    logic [15:0] wr_count;

    int          n_vec;
    int          n_miscmp;
    int          n_xfer;
    int          ready_mode;
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;

    conv_result_writeback_if #(.RESULT_SIZE(32), .DATA_WIDTH(8), .ADDR_SIZE(16)) bus ();

    conv_result_writeback #(
        .RESULT_SIZE (32),
        .DATA_WIDTH  (8),
        .ADDR_SIZE   (16),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_shift    (cfg_shift),
        .cfg_relu_en  (cfg_relu_en),
        .cfg_expected (cfg_expected),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .count_err    (count_err),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: floor((d + half) / 2^sh), optional ReLU, clamp to int8.
    function automatic logic [7:0] ref_quant(input logic [31:0] d, input int sh, input bit relu);
        longint r;
        r = longint'($signed(d));
        if (sh > 0) begin
            r = r + (longint'(1) <<< (sh - 1));
        end
        r = r >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20000)) - 32'd10000;
            default: return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    // Output-side ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Transfer monitor: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 64'(bus.out_valid), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer_addr", 64'(bus.out_addr), 64'(mon_e[23:8]));
                chk("xfer_data", 64'(bus.out_data), 64'(mon_e[7:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input bit last,
                            input bit push, input logic [7:0] exp_d);
        bus.in_ena    = 1'b1;
        bus.in_wea    = 1'b1;
        bus.in_addr   = a;
        bus.in_data   = d;
        bus.in_w_done = last;
        if (push) exp_q.push_back({a, exp_d});
        tick();
        bus.in_ena    = 1'b0;
        bus.in_wea    = 1'b0;
        bus.in_w_done = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("done_seen", 64'(done), 64'(1));
        if (done === 1'b1) begin
            chk("done_count_err", 64'(count_err), 64'(exp_err));
            chk("done_busy", 64'(busy), 64'(0));
            tick();
            chk("done_width", 64'(done), 64'(0));
            chk("err_sticky", 64'(count_err), 64'(exp_err));
            chk("queue_drained", 64'(exp_q.size()), 64'(0));
        end
    endtask

    initial begin
        int x0;
        n_vec = 0; n_miscmp = 0; n_xfer = 0; ready_mode = 1;
        rst = 1'b1; start = 1'b0; cfg_shift = '0; cfg_relu_en = 1'b0; cfg_expected = '0;
        bus.in_ena = 1'b0; bus.in_wea = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.in_w_done = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_count_err", 64'(count_err), 64'(0));
        chk("rst_wr_count", 64'(wr_count), 64'(0));
        chk("rst_out_addr", 64'(bus.out_addr), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        rst = 1'b0;
        tick();

        // Rounded shift and three-cycle latency: 0x128 >> 4 rounds 18.5 up to 19.
        cfg_shift = 5'd4; cfg_relu_en = 1'b0; cfg_expected = 16'd1;
        start_pulse();
        chk("run_busy", 64'(busy), 64'(1));
        do_write(16'h0040, 32'h0000_0128, 1'b1, 1'b1, 8'h13);
        chk("lat_n1", 64'(bus.out_valid), 64'(0));
        tick();
        chk("lat_n2", 64'(bus.out_valid), 64'(0));
        tick();
        chk("lat_n3_valid", 64'(bus.out_valid), 64'(1));
        chk("lat_n3_data", 64'(bus.out_data), 64'(8'h13));
        chk("lat_n3_addr", 64'(bus.out_addr), 64'(16'h0040));
        wait_done(1'b0);

        // Saturation and ReLU.
        cfg_shift = 5'd0; cfg_relu_en = 1'b0; cfg_expected = 16'd2;
        start_pulse();
        do_write(16'h0001, 32'hFFFF_EC78, 1'b0, 1'b1, 8'h80);
        do_write(16'h0002, 32'd200, 1'b1, 1'b1, 8'h7F);
        wait_done(1'b0);
        cfg_relu_en = 1'b1; cfg_expected = 16'd1;
        start_pulse();
        do_write(16'h0003, 32'hFFFF_EC78, 1'b1, 1'b1, 8'h00);
        wait_done(1'b0);

        // Overflow: ten writes into an eight-deep FIFO with the output stalled.
        ready_mode = 0; cfg_relu_en = 1'b0; cfg_shift = 5'd0; cfg_expected = 16'd10;
        tick();
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            do_write(16'(100 + i), 32'(3 * i), i == 9, i < 8, 8'(3 * i));
        end
        repeat (6) tick();
        chk("ovf_flag", 64'(overflow), 64'(1));
        chk("ovf_wr_count", 64'(wr_count), 64'(10));
        chk("ovf_busy_drain", 64'(busy), 64'(1));
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        repeat (3) tick();
        chk("stall_addr", 64'(bus.out_addr), 64'(exp_q[0][23:8]));
        chk("stall_data", 64'(bus.out_data), 64'(exp_q[0][7:0]));
        x0 = n_xfer;
        ready_mode = 1;
        wait_done(1'b0);
        chk("ovf_xfers", 64'(n_xfer - x0), 64'(8));
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Count check: 16 writes then 15 writes against 16 expected.
        cfg_shift = 5'd2; cfg_expected = 16'd16;
        start_pulse();
        chk("start_clears_ovf", 64'(overflow), 64'(0));
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = rand_data();
            do_write(16'(i), d, i == 15, 1'b1, ref_quant(d, 2, 1'b0));
        end
        wait_done(1'b0);
        chk("cnt16_wr_count", 64'(wr_count), 64'(16));
        start_pulse();
        for (int i = 0; i < 15; i++) begin
            logic [31:0] d;
            d = rand_data();
            do_write(16'(i), d, i == 14, 1'b1, ref_quant(d, 2, 1'b0));
        end
        wait_done(1'b1);
        start_pulse();
        chk("start_clears_err", 64'(count_err), 64'(0));

        // Reset while draining with three entries held in the FIFO.
        ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            do_write(16'(i), 32'(i), i == 2, 1'b1, 8'(i));
        end
        repeat (4) tick();
        chk("pre_rst_busy", 64'(busy), 64'(1));
        chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("rst_drain_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_drain_busy", 64'(busy), 64'(0));
        chk("rst_drain_wr_count", 64'(wr_count), 64'(0));
        chk("rst_drain_done", 64'(done), 64'(0));
        rst = 1'b0;
        ready_mode = 1;
        tick();

        // Start while busy is ignored; writes in IDLE are ignored.
        cfg_expected = 16'd3;
        start_pulse();
        do_write(16'h0010, 32'd16, 1'b0, 1'b1, 8'd4);
        do_write(16'h0011, 32'd20, 1'b0, 1'b1, 8'd5);
        start_pulse();
        chk("busy_start_wr_count", 64'(wr_count), 64'(2));
        chk("busy_start_busy", 64'(busy), 64'(1));
        do_write(16'h0012, 32'd24, 1'b1, 1'b1, 8'd6);
        wait_done(1'b0);
        for (int i = 0; i < 3; i++) begin
            do_write(16'(i), 32'd1000, 1'b0, 1'b0, 8'h00);
        end
        repeat (4) tick();
        chk("idle_wr_count", 64'(wr_count), 64'(3));
        chk("idle_valid", 64'(bus.out_valid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));

        // Randomised convolutions, up to eight writes each with random backpressure.
        ready_mode = 2;
        for (int c = 0; c < 30; c++) begin
            int n;
            int sh;
            bit rl;
            n  = $urandom_range(1, 8);
            sh = $urandom_range(0, 31);
            rl = 1'($urandom_range(0, 1));
            cfg_shift    = 5'(sh);
            cfg_relu_en  = rl;
            cfg_expected = $urandom_range(0, 1) ? 16'(n) : 16'($urandom_range(0, 10));
            start_pulse();
            for (int w = 0; w < n; w++) begin
                logic [31:0] d;
                d = rand_data();
                do_write(16'($urandom), d, w == n - 1, 1'b1, ref_quant(d, sh, rl));
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_done(cfg_expected != 16'(n));
            chk("rnd_wr_count", 64'(wr_count), 64'(n));
            chk("rnd_overflow", 64'(overflow), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/conv_result_writeback.md
CONV_RESULT_WRITEBACK -- requirements
Module: conv_result_writeback

Interface
REQ-001 SHALL have parameter RESULT_SIZE, 32, signed accumulator width of each result word from the GEMM result path.
REQ-002 SHALL have parameter DATA_WIDTH, 8, signed width of each requantised output word.
REQ-003 SHALL have parameter ADDR_SIZE, 16, width of the output RAM address.
REQ-004 SHALL have parameter FIFO_DEPTH, 8, output FIFO depth in entries (power of two).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle pulse that begins one convolution writeback.
REQ-008 SHALL have port cfg_shift, input, 5, arithmetic right-shift amount for requantisation.
REQ-009 SHALL have port cfg_relu_en, input, 1, clamps negative results to 0 when set.
REQ-010 SHALL have port cfg_expected, input, ADDR_SIZE, expected number of result writes per convolution.
REQ-011 SHALL have ports in_ena, input, 1, and in_wea, input, 1, the upstream result RAM enable and write enable.
REQ-012 SHALL have port in_addr, input, ADDR_SIZE, result address.
REQ-013 SHALL have port in_data, input, RESULT_SIZE, signed result.
REQ-014 SHALL have port in_w_done, input, 1, upstream pulse marking the last write.
REQ-015 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_addr, output, ADDR_SIZE; and out_data, output, DATA_WIDTH, the output RAM write channel.
REQ-016 SHALL have ports busy, output, 1; done, output, 1; overflow, output, 1; count_err, output, 1; and wr_count, output, ADDR_SIZE.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE, with transitions as follows:
- IDLE -> RUN on start.
- RUN -> DRAIN on in_w_done.
- DRAIN -> DONE when both pipeline stages and the FIFO are empty.
- DONE -> IDLE after exactly one cycle.
REQ-018 SHALL accept a write only in the RUN state with in_ena=1 and in_wea=1; an input in any other state is ignored.
REQ-019 SHALL, on a start pulse in IDLE, clear wr_count, overflow, count_err and the FIFO; a start pulse in any other state is ignored.
REQ-020 SHALL, in stage 1 (registered, cycle N+1), compute r = (in_data + (cfg_shift>0 ? 2^(cfg_shift-1) : 0)) >>> cfg_shift in RESULT_SIZE+1 signed bits, with no wrap.
REQ-021 SHALL, in stage 2 (registered, cycle N+2), apply ReLU if enabled, then saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and push {addr, data} into the FIFO.
REQ-022 SHALL present a pushed entry on out_valid no earlier than cycle N+3 when the FIFO was empty (first-word-fall-through).
REQ-023 SHALL transfer an entry only when out_valid && out_ready; out_addr and out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drop a push attempted while the FIFO is full with no pop in the same cycle, and set overflow (sticky until start or rst); if a pop occurs in the same cycle, the push SHALL be accepted.
REQ-025 SHALL increment wr_count once per accepted input write, saturating at all-ones.
REQ-026 SHALL accept a write that arrives in the same cycle as in_w_done.
REQ-027 SHALL, in DONE, pulse done for 1 cycle and set count_err (sticky) if wr_count != cfg_expected.
REQ-028 SHALL drive busy = 1 in RUN and DRAIN, else 0.

Reset
REQ-029 SHALL, on rst, enter IDLE, empty the FIFO and both pipeline stages, and zero all outputs (out_valid, done, busy, overflow, count_err, wr_count, out_addr, out_data).
REQ-030 SHALL, on rst asserted mid-RUN or mid-DRAIN, discard in-flight data with no out_valid on the following cycle.

Structure
REQ-031 SHALL take RESULT_SIZE, DATA_WIDTH and ADDR_SIZE defaults and the FSM state encodings from the shared define file.
REQ-032 SHALL instantiate one sub-module, sync_fifo (width ADDR_SIZE+DATA_WIDTH, depth FIFO_DEPTH, synchronous active-high rst).

Verification
REQ-033 SHALL cover: cfg_shift=4, relu=0, in_data=0x00000128 -> out_data 0x13 (rounded 18.5 -> 19) at cycle N+3.
REQ-034 SHALL cover: in_data=-5000, shift=0, relu=0 -> out_data 0x80; relu=1 -> 0x00; in_data=200 -> 0x7F.
REQ-035 SHALL cover: FIFO_DEPTH=8, out_ready=0, 10 consecutive writes -> 8 stored, overflow=1; releasing out_ready -> exactly 8 transfers, in order.
REQ-036 SHALL cover: cfg_expected=16, 16 writes with in_w_done on the last -> drain, done pulse 1 cycle, count_err=0; repeat with 15 writes -> count_err=1.
REQ-037 SHALL cover: rst during DRAIN with 3 FIFO entries -> next cycle out_valid=0, busy=0, wr_count=0, state IDLE.
REQ-038 SHALL cover: start while busy -> ignored; writes in IDLE -> no FIFO push, wr_count unchanged.
